// File: rtl/ecc_seq_pkg.sv
// Shared definitions for the operand-RAM sequencer of the scalar-multiplier datapath:
// default widths, the watchdog limit and the FSM state encoding.
package ecc_seq_pkg;

    localparam int DEF_DATA    = 256;
    localparam int DEF_ADDR    = 3;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WB    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Multiplier-response watchdog. A clear pulse reloads the timer with TIMEOUT-1;
// while enabled it counts down and flags expiry at terminal count zero, which is
// reached on the TIMEOUT-th enabled cycle after the clear.
module seq_watchdog
    import ecc_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Down-counter: reload on clear, hold at zero once the terminal count is hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = enable && (cnt == '0);

endmodule

// File: rtl/ram_op_sequencer.sv
// Operand-RAM sequencer: reads two operands in parallel on RAM ports A and B,
// launches the field multiplier and writes the product back through port A.
// Optional build macro SEQ_TIMEOUT_EN adds a multiplier-response watchdog that
// abandons the operation (err pulse, no write-back) after TIMEOUT cycles in WAIT.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// READ  | both RAM ports addressed with the sources, RAM registers data
// CAPT  | RAM read data valid, captured into the operand registers
// ISSUE | mul_start pulse, operands stable
// WAIT  | waiting for mul_done (watchdog running when enabled)
// WB    | product written to dst through port A, done pulse
module ram_op_sequencer
    import ecc_seq_pkg::*;
#(
    parameter int DATA    = DEF_DATA,
    parameter int ADDR    = DEF_ADDR,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [ADDR-1:0] cmd_src_a,
    input  logic [ADDR-1:0] cmd_src_b,
    input  logic [ADDR-1:0] cmd_dst,
    output logic            a_w,
    output logic [ADDR-1:0] a_adbus,
    output logic [DATA-1:0] a_data_in,
    input  logic [DATA-1:0] a_data_out,
    output logic            b_w,
    output logic [ADDR-1:0] b_adbus,
    output logic [DATA-1:0] b_data_in,
    input  logic [DATA-1:0] b_data_out,
    output logic            mul_start,
    output logic [DATA-1:0] mul_op_a,
    output logic [DATA-1:0] mul_op_b,
    input  logic            mul_done,
    input  logic [DATA-1:0] mul_result,
    output logic            busy,
    output logic            done,
    output logic            err
);

    seq_state_t      state;
    logic [ADDR-1:0] src_a_q;
    logic [ADDR-1:0] src_b_q;
    logic [ADDR-1:0] dst_q;
    logic [DATA-1:0] result_q;

`ifdef SEQ_TIMEOUT_EN
    logic wd_expired;
    logic err_q;

    // Timer restarts on the ISSUE->WAIT transition and runs only while waiting.
    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .expired (wd_expired)
    );

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Port B is read-only; port A switches to the destination only while writing back.
    assign b_w       = 1'b0;
    assign b_data_in = '0;
    assign b_adbus   = src_b_q;
    assign a_adbus   = a_w ? dst_q : src_a_q;
    assign a_data_in = result_q;

    // Sequencing FSM; every strobe is registered from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            src_a_q   <= '0;
            src_b_q   <= '0;
            dst_q     <= '0;
            result_q  <= '0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            a_w       <= 1'b0;
            mul_start <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            a_w       <= 1'b0;
            mul_start <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        src_a_q   <= cmd_src_a;
                        src_b_q   <= cmd_src_b;
                        dst_q     <= cmd_dst;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    state <= ST_CAPT;
                end
                ST_CAPT: begin
                    mul_op_a  <= a_data_out;
                    mul_op_b  <= b_data_out;
                    mul_start <= 1'b1;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response on the limit cycle still wins over the timeout.
                    if (mul_done) begin
                        result_q <= mul_result;
                        a_w      <= 1'b1;
                        done     <= 1'b1;
                        state    <= ST_WB;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wd_expired) begin
                        err_q     <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
`endif
                end
                ST_WB: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_op_sequencer.sv
// Directed bench for ram_op_sequencer: behavioural dual-port RAM, fixed-latency
// multiplier model and an edge recorder used for latency measurements.
module tb_ram_op_sequencer;

    localparam int DATA = 256;
    localparam int ADDR = 3;
    localparam int TO   = 16;
    localparam int M    = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [ADDR-1:0] cmd_src_a;
    logic [ADDR-1:0] cmd_src_b;
    logic [ADDR-1:0] cmd_dst;
    logic            a_w;
    logic [ADDR-1:0] a_adbus;
    logic [DATA-1:0] a_data_in;
    logic [DATA-1:0] a_data_out;
    logic            b_w;
    logic [ADDR-1:0] b_adbus;
    logic [DATA-1:0] b_data_in;
    logic [DATA-1:0] b_data_out;
    logic            mul_start;
    logic [DATA-1:0] mul_op_a;
    logic [DATA-1:0] mul_op_b;
    logic            mul_done;
    logic [DATA-1:0] mul_result;
    logic            busy;
    logic            done;
    logic            err;

    always #5 clk = ~clk;

    ram_op_sequencer #(.DATA(DATA), .ADDR(ADDR), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_dst    (cmd_dst),
        .a_w        (a_w),
        .a_adbus    (a_adbus),
        .a_data_in  (a_data_in),
        .a_data_out (a_data_out),
        .b_w        (b_w),
        .b_adbus    (b_adbus),
        .b_data_in  (b_data_in),
        .b_data_out (b_data_out),
        .mul_start  (mul_start),
        .mul_op_a   (mul_op_a),
        .mul_op_b   (mul_op_b),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Dual-port RAM with registered reads, plus a bench preload port.
    logic [DATA-1:0] mem [8];
    logic            pre_we = 1'b0;
    logic [ADDR-1:0] pre_addr = '0;
    logic [DATA-1:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (a_w) mem[a_adbus] <= a_data_in;
        a_data_out <= mem[a_adbus];
        b_data_out <= mem[b_adbus];
    end

    // Multiplier model: done is seen by the sequencer M edges after mul_start is sampled.
    logic            mul_en = 1'b1;
    logic            inj_done = 1'b0;
    logic            mdl_done = 1'b0;
    logic [DATA-1:0] prod_q = '0;
    int              mcnt = 0;
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (mul_en && mul_start) begin
            mcnt   <= M - 1;
            prod_q <= mul_op_a * mul_op_b;
        end else if (mcnt > 0) begin
            if (mcnt == 1) mdl_done <= mul_en;
            mcnt <= mcnt - 1;
        end
    end
    assign mul_done   = mdl_done | inj_done;
    assign mul_result = prod_q;

    // Edge recorder: cycle numbers of accepts, starts, writes, done and err.
    int              cyc = 0;
    int              acc_cnt = 0, acc_last = 0, acc_prev = 0;
    int              start_cnt = 0, start_cyc = 0;
    int              wr_cnt = 0, wr_cyc = 0;
    logic [ADDR-1:0] wr_addr = '0;
    int              done_cnt = 0;
    int              err_cnt = 0, err_cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && cmd_valid && cmd_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_prev <= acc_last;
            acc_last <= cyc;
        end
        if (mul_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (a_w) begin
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_addr <= a_adbus;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic preload(input logic [ADDR-1:0] addr, input logic [DATA-1:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic issue_cmd(input logic [ADDR-1:0] a, input logic [ADDR-1:0] b,
                             input logic [ADDR-1:0] d);
        int start_acc;
        start_acc = acc_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_cnt != start_acc) break;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (acc_cnt == start_acc) $display("FAIL accept_timeout cmd (%0d,%0d,%0d) not accepted in 100 cycles", a, b, d);
        else n_pass++;
    endtask

    task automatic wait_write(input int prev_wr);
        for (int i = 0; i < 200; i++) begin
            if (wr_cnt != prev_wr) break;
            @(negedge clk);
        end
        n_checks++;
        if (wr_cnt == prev_wr) $display("FAIL write_timeout no write-back within 200 cycles");
        else n_pass++;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_src_a = '0;
        cmd_src_b = '0;
        cmd_dst   = '0;
        #2;
        n_checks++;
        if ({cmd_ready, a_w, mul_start, done, err, busy} !== 6'b0)
            $display("FAIL reset_strobes got %b exp 000000", {cmd_ready, a_w, mul_start, done, err, busy});
        else n_pass++;
        n_checks++;
        if (mul_op_a !== '0 || mul_op_b !== '0 || a_data_in !== '0)
            $display("FAIL reset_regs op_a=%0h op_b=%0h a_data_in=%0h exp 0", mul_op_a, mul_op_b, a_data_in);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_release cmd_ready=%b busy=%b exp 1 0", cmd_ready, busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        int wr0, dn0;
        preload(3'd1, 256'h5);
        preload(3'd2, 256'h7);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        issue_cmd(3'd1, 3'd2, 3'd3);
        n_checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0)
            $display("FAIL basic_busy busy=%b cmd_ready=%b exp 1 0", busy, cmd_ready);
        else n_pass++;
        wait_write(wr0);
        n_checks++;
        if (start_cyc - acc_last !== 3) $display("FAIL basic_start_lat got %0d exp 3", start_cyc - acc_last);
        else n_pass++;
        n_checks++;
        if (wr_cyc - acc_last !== 3 + M + 1) $display("FAIL basic_wr_lat got %0d exp %0d", wr_cyc - acc_last, 3 + M + 1);
        else n_pass++;
        n_checks++;
        if (mul_op_a !== 256'h5 || mul_op_b !== 256'h7)
            $display("FAIL basic_ops got %0h,%0h exp 5,7", mul_op_a, mul_op_b);
        else n_pass++;
        n_checks++;
        if (mem[3] !== 256'h23 || wr_addr !== 3'd3)
            $display("FAIL basic_result mem3=%0h addr=%0d exp 23 3", mem[3], wr_addr);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL basic_ready_back cmd_ready=%b busy=%b exp 1 0", cmd_ready, busy);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt - dn0 !== 1 || wr_cnt - wr0 !== 1)
            $display("FAIL basic_pulses done=%0d writes=%0d exp 1 1", done_cnt - dn0, wr_cnt - wr0);
        else n_pass++;
    endtask

    task automatic test_same_addr();
        int wr0, dn0;
        preload(3'd4, 256'hFFFF);
        wr0 = wr_cnt;
        dn0 = done_cnt;
        issue_cmd(3'd4, 3'd4, 3'd4);
        repeat (4) @(negedge clk);
        n_checks++;
        if (mem[4] !== 256'hFFFF) $display("FAIL same_early_write mem4=%0h exp ffff before WB", mem[4]);
        else n_pass++;
        wait_write(wr0);
        n_checks++;
        if (mul_op_a !== 256'hFFFF || mul_op_b !== 256'hFFFF)
            $display("FAIL same_ops got %0h,%0h exp ffff,ffff", mul_op_a, mul_op_b);
        else n_pass++;
        n_checks++;
        if (mem[4] !== 256'hFFFE0001 || wr_cnt - wr0 !== 1 || done_cnt - dn0 !== 1)
            $display("FAIL same_result mem4=%0h writes=%0d done=%0d exp fffe0001 1 1", mem[4], wr_cnt - wr0, done_cnt - dn0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc0, wr0;
        preload(3'd5, 256'h3);
        preload(3'd6, 256'h9);
        acc0 = acc_cnt;
        wr0  = wr_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_src_a = 3'd1;
        cmd_src_b = 3'd2;
        cmd_dst   = 3'd0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_cnt != acc0) break;
        end
        cmd_src_a = 3'd5;
        cmd_src_b = 3'd6;
        cmd_dst   = 3'd7;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_cnt - acc0 >= 2) break;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (acc_cnt - acc0 !== 2) $display("FAIL b2b_accepts got %0d exp 2", acc_cnt - acc0);
        else n_pass++;
        n_checks++;
        if (acc_last - acc_prev !== M + 5) $display("FAIL b2b_spacing got %0d exp %0d", acc_last - acc_prev, M + 5);
        else n_pass++;
        wait_write(wr0 + 1);
        n_checks++;
        if (mul_op_a !== 256'h3 || mul_op_b !== 256'h9)
            $display("FAIL b2b_ops got %0h,%0h exp 3,9", mul_op_a, mul_op_b);
        else n_pass++;
        n_checks++;
        if (mem[0] !== 256'h23 || mem[7] !== 256'h1B)
            $display("FAIL b2b_results mem0=%0h mem7=%0h exp 23 1b", mem[0], mem[7]);
        else n_pass++;
    endtask

    task automatic test_spurious_done();
        int wr0, dn0;
        wr0 = wr_cnt;
        dn0 = done_cnt;
        issue_cmd(3'd1, 3'd2, 3'd5);
        inj_done = 1'b1;
        repeat (2) @(negedge clk);
        inj_done = 1'b0;
        n_checks++;
        if (a_w !== 1'b0 || busy !== 1'b1) $display("FAIL spur_early a_w=%b busy=%b exp 0 1", a_w, busy);
        else n_pass++;
        wait_write(wr0);
        n_checks++;
        if (wr_cyc - acc_last !== 3 + M + 1) $display("FAIL spur_wr_lat got %0d exp %0d", wr_cyc - acc_last, 3 + M + 1);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem[5] !== 256'h23 || done_cnt - dn0 !== 1)
            $display("FAIL spur_result mem5=%0h done=%0d exp 23 1", mem[5], done_cnt - dn0);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int wr0, dn0;
        preload(3'd6, 256'hAA);
        mul_en = 1'b0;
        wr0 = wr_cnt;
        dn0 = done_cnt;
        issue_cmd(3'd1, 3'd2, 3'd6);
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL abort_in_wait busy=%b exp 1", busy);
        else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL abort_idle busy=%b cmd_ready=%b exp 0 1", busy, cmd_ready);
        else n_pass++;
        n_checks++;
        if (wr_cnt != wr0 || done_cnt != dn0 || mem[6] !== 256'hAA)
            $display("FAIL abort_stale writes=%0d done=%0d mem6=%0h exp 0 0 aa", wr_cnt - wr0, done_cnt - dn0, mem[6]);
        else n_pass++;
        // Second abort: reset lands in the write-back cycle itself.
        issue_cmd(3'd1, 3'd2, 3'd6);
        repeat (3) @(negedge clk);
        inj_done = 1'b1;
        @(posedge clk);
        #1;
        inj_done = 1'b0;
        n_checks++;
        if (a_w !== 1'b1) $display("FAIL abort_wb_enter a_w=%b exp 1", a_w);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_w !== 1'b0 || done !== 1'b0) $display("FAIL abort_wb_async a_w=%b done=%b exp 0 0", a_w, done);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_cnt != wr0 || done_cnt != dn0 || mem[6] !== 256'hAA)
            $display("FAIL abort_wb_nowrite writes=%0d done=%0d mem6=%0h exp 0 0 aa", wr_cnt - wr0, done_cnt - dn0, mem[6]);
        else n_pass++;
        mul_en = 1'b1;
    endtask

`ifdef SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int wr0, dn0, er0;
        mul_en = 1'b0;
        wr0 = wr_cnt;
        dn0 = done_cnt;
        er0 = err_cnt;
        issue_cmd(3'd1, 3'd2, 3'd6);
        for (int i = 0; i < 100; i++) begin
            if (err_cnt != er0) break;
            @(negedge clk);
        end
        n_checks++;
        if (err_cnt - er0 !== 1) $display("FAIL timeout_err_count got %0d exp 1", err_cnt - er0);
        else n_pass++;
        n_checks++;
        if (err_cyc - acc_last !== 3 + TO + 1) $display("FAIL timeout_lat got %0d exp %0d", err_cyc - acc_last, 3 + TO + 1);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1 || err !== 1'b0)
            $display("FAIL timeout_after cmd_ready=%b err=%b exp 1 0", cmd_ready, err);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_cnt != wr0 || done_cnt != dn0 || err_cnt - er0 !== 1 || mem[6] !== 256'hAA)
            $display("FAIL timeout_nowrite writes=%0d done=%0d errs=%0d mem6=%0h exp 0 0 1 aa", wr_cnt - wr0, done_cnt - dn0, err_cnt - er0, mem[6]);
        else n_pass++;
        mul_en = 1'b1;
    endtask
`else
    task automatic test_timeout();
        repeat (2) @(negedge clk);
        n_checks++;
        if (err_cnt != 0) $display("FAIL err_tied_low err pulses=%0d exp 0", err_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_same_addr();
        test_back_to_back();
        test_spurious_done();
        test_reset_abort();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_op_sequencer.md
Name: ram_op_sequencer

Overview:
Control stage directly upstream of the dual-port operand RAM (8 x 256-bit) in the scalar-multiplier datapath. It accepts one command (src_a, src_b, dst) and reads both operands in parallel on RAM ports A and B. It launches the field multiplier and writes the product back to RAM address dst through port A. It is the only bus master of the RAM during field multiplications.

Parameters:
DATA, 256, operand/result width in bits
ADDR, 3, RAM address width (8 entries)
TIMEOUT, 1024, watchdog limit in cycles for mul_done (used only with SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_src_a  in  ADDR  RAM address of operand A
cmd_src_b  in  ADDR  RAM address of operand B
cmd_dst  in  ADDR  RAM address for result
a_w  out  1  RAM port A write enable
a_adbus  out  ADDR  RAM port A address
a_data_in  out  DATA  RAM port A write data
a_data_out  in  DATA  RAM port A registered read data
b_w  out  1  RAM port B write enable (always 0)
b_adbus  out  ADDR  RAM port B address
b_data_in  out  DATA  RAM port B write data (always 0)
b_data_out  in  DATA  RAM port B registered read data
mul_start  out  1  one-cycle multiplier start pulse
mul_op_a  out  DATA  registered operand A
mul_op_b  out  DATA  registered operand B
mul_done  in  1  multiplier result valid (single-cycle pulse)
mul_result  in  DATA  multiplier product
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, high in the cycle the write-back is issued
err  out  1  one-cycle timeout pulse (constant 0 without SEQ_TIMEOUT_EN)

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. Reset forces state IDLE. All registered outputs and internal registers reset to 0: mul_op_a/b, the result register, the src/dst registers and the watchdog count. a_w=0, mul_start=0, done=0 and err=0 while in reset. cmd_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE -> READ -> CAPT -> ISSUE -> WAIT -> WB -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at a rising edge, register src_a/src_b/dst and go to READ.
- READ: a_adbus=src_a, b_adbus=src_b, a_w=0. The RAM registers its read data at the end of this cycle.
- CAPT: a_data_out and b_data_out are valid. Load them into mul_op_a and mul_op_b at the end of the cycle.
- ISSUE: mul_start=1 for exactly this cycle; operands are stable. Go to WAIT.
- WAIT: hold mul_op_a/b. On mul_done=1, load mul_result into the result register and go to WB. mul_done is ignored in every other state, including a stale pulse after reset.
- WB: a_w=1, a_adbus=dst, a_data_in=result register, done=1. The RAM write lands at the end of WB. Go to IDLE.
- Outside READ/CAPT, b_adbus holds src_b. Outside WB, a_adbus holds src_a and a_data_in holds the result register.
- Fixed latency: command accept edge to mul_start is 3 cycles. mul_done edge to the RAM write edge is 1 cycle. With a multiplier latency of M cycles, back-to-back commands are spaced M+5 cycles.
- src_a==src_b is legal: both ports read the same entry. dst equal to a source is legal; the overwrite happens only in WB, after both operands are captured.
- cmd_valid while busy is not accepted (cmd_ready=0). The command must be held until accepted.
- rst mid-operation aborts with no RAM write, even in WB.

Optional Feature:
SEQ_TIMEOUT_EN. When defined:
- A counter clears on entry to WAIT and increments every WAIT cycle.
- If it reaches TIMEOUT-1 without mul_done, err=1 for one cycle and the FSM returns to IDLE with no write-back and no done.
- mul_done arriving in the same cycle as the limit takes priority: normal WB, no err.
When undefined: no counter logic, err tied 0, WAIT waits indefinitely.

Decomposition:
- Package ecc_seq_pkg holds:
  - the DATA and ADDR defaults;
  - the state encoding (IDLE=0, READ=1, CAPT=2, ISSUE=3, WAIT=4, WB=5, 3-bit);
  - the TIMEOUT default.
- One natural sub-module: seq_watchdog (clear/enable/expired; counter of width $clog2(TIMEOUT)). It is instantiated only under SEQ_TIMEOUT_EN.

Test Plan:
1. Preload RAM[1]=0x5, RAM[2]=0x7; command (1,2,3); multiplier model returns op_a*op_b after 10 cycles -> mul_start 3 cycles after accept, mul_op_a=5, mul_op_b=7, RAM[3]=0x23, done pulse once, cmd_ready back next cycle.
2. Command (4,4,4) with RAM[4]=0xFFFF -> both ports read address 4, mul_op_a=mul_op_b=0xFFFF, RAM[4]=0xFFFE0001 written only in WB.
3. Two commands back-to-back with cmd_valid held high; multiplier latency M=10 -> second accept exactly 15 cycles after the first, second operands correct.
4. Assert rst in WAIT, then pulse mul_done 2 cycles after release -> no a_w ever asserted, done=0, state IDLE, the stale mul_done is ignored.
5. Inject mul_done in READ and CAPT -> ignored; the sequence completes only on the mul_done that arrives in WAIT.
6. (SEQ_TIMEOUT_EN, TIMEOUT=16) Multiplier never responds -> err pulses once exactly 16 cycles after WAIT entry, no RAM write, cmd_ready=1 the next cycle.
